code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Sits directly upstream of the instruction code memory. It is the only writer on that memory's write port (we/w_addr/w_data).
- Consumes the byte stream from the UART receiver.
- Frame format: a 4-byte word count N, followed by N 32-bit instruction words.
- It writes the words to consecutive word addresses starting at 0, then signals done so the core can be released from hold.

Parameters:
- CODE_SIZE, 32767, highest valid word address of the code memory; matches the memory's own CODE_SIZE.
- BIG_ENDIAN, 0, byte order within each word and within N. 0 = first byte received is bits [7:0]; 1 = first byte received is bits [31:24].

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- restart  input  1  one-cycle pulse: re-arm for a new frame. Honoured only in S_DONE.
- we  output  1  code memory write enable; one cycle per word.
- w_addr  output  32  code memory word address.
- w_data  output  32  code memory write data.
- loading  output  1  high while in S_LEN or S_DATA with a frame in progress.
- done  output  1  high in S_DONE.
- overflow  output  1  sticky flag: at least one word was dropped because its address was > CODE_SIZE.
- words_loaded  output  32  count of words accepted in the current frame.

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - state = S_LEN.
  - Byte counter, shift register, word count and address counter = 0.
  - Outputs: we=0, w_addr=0, w_data=0, loading=0, done=0, overflow=0, words_loaded=0.
  - Code memory contents are not touched.
- Byte assembler:
  - 2-bit byte counter and 32-bit shift register. Each rx_valid cycle shifts rx_data in according to BIG_ENDIAN.
  - On the 4th byte, word_valid pulses for one cycle carrying the full word; the counter wraps to 0.
  - rx_valid is ignored in S_DONE, so the counter does not advance there.
- States:
  - S_LEN:
    - loading goes high on the first rx_valid.
    - On word_valid, latch N.
    - N == 0: next state S_DONE.
    - Otherwise: next state S_DATA, address counter = 0.
  - S_DATA, on word_valid:
    - Next cycle: we=1, w_addr=address counter, w_data=word.
    - Address counter and words_loaded increment.
    - If the address counter > CODE_SIZE: we stays 0, overflow is set, and words_loaded still increments.
    - When words_loaded reaches N (on the Nth word), the next state is S_DONE.
  - S_DONE:
    - done=1, loading=0, we=0.
    - restart → S_LEN; clears done, words_loaded, byte counter and address counter. overflow is also cleared.
    - rx bytes in S_DONE are dropped.
- Timing:
  - we is registered: it asserts exactly 1 cycle after the rx_valid cycle carrying the word's 4th byte, and lasts exactly 1 cycle.
  - done asserts in the same cycle as the final word's we.
  - Back-to-back rx_valid on every cycle is supported, so a word completes every 4 cycles with no stall. There is no backpressure; the memory always accepts.
- Boundaries:
  - N = CODE_SIZE+1: last write goes to address CODE_SIZE; overflow stays 0.
  - N = 0xFFFFFFFF: the frame ends only on reset; address-counter wrap is irrelevant because writes are suppressed above CODE_SIZE.
  - restart outside S_DONE is ignored.
  - restart together with rx_valid in S_DONE: the byte is dropped, and the state moves to S_LEN on the next cycle.
  - rst mid-frame: partial word is discarded, and the loader waits for a new length header.

Decomposition:
- Package loader_pkg holds:
  - typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE} loader_state_t;
  - localparam BYTES_PER_WORD = 4.
- Sub-module byte_assembler holds the byte counter, shift register and word_valid pulse, with BIG_ENDIAN as a parameter.
- code_loader holds the FSM, the counters and the registered write port.

Test Plan:
- Reset, then bytes 02 00 00 00, 13 00 00 00, EF BE AD DE (LE) → we pulses at addr 0 data 0x00000013, then at addr 1 data 0xDEADBEEF; done=1 in the cycle of the second we; words_loaded=2.
- BIG_ENDIAN=1, bytes 00 00 00 01, 12 34 56 78 → single write addr 0 data 0x12345678; done=1.
- N=0 (00 00 00 00) → no we ever; done=1 the cycle after the 4th byte; further rx bytes cause no writes.
- CODE_SIZE=3, N=5, words 1..5 → writes at addresses 0..3 only; 5th word dropped; overflow=1; words_loaded=5; done=1.
- Assert rst after 2 data bytes of word 1 (N=2), then send full frame N=1 word 0xAABBCCDD → single write addr 0 data 0xAABBCCDD; no stale bytes mixed in.
- After done, pulse restart, send N=1 word 0x00000073 → write at addr 0; overflow and words_loaded cleared before the new frame; done re-asserts.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and helpers for the code loader.
//   loader_state_t  : FSM encoding (length header, data words, finished)
//   BYTES_PER_WORD  : bytes assembled into one 32-bit instruction word
//   shift_in_byte() : folds one received byte into the word accumulator
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Little-endian shifts new bytes in from the top so the first byte ends up
    // in [7:0]; big-endian shifts in from the bottom so the first byte ends up
    // in [31:24].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc,
                                                  input logic [7:0]  data,
                                                  input logic        big_endian);
        logic [31:0] res;
        if (big_endian) begin
            res = {acc[23:0], data};
        end else begin
            res = {data, acc[31:8]};
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects four bytes into one 32-bit word.
//   clk, rst    : clock and asynchronous active-high reset
//   clear       : synchronous clear of the byte counter and accumulator
//   byte_en     : byte_data holds a byte to accept this cycle
//   byte_data   : incoming byte
//   word_valid  : combinational pulse in the cycle the 4th byte is accepted
//   word        : completed word, valid while word_valid is high
module byte_assembler
    import loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_r;
    logic [31:0] shift_r;
    logic [31:0] next_s;

    assign next_s = shift_in_byte(shift_r, byte_data, BIG_ENDIAN);

    // The word is presented combinationally with its last byte so the loader
    // can register the memory write on that same edge.
    always_comb begin
        word_valid = 1'b0;
        word       = next_s;
        if (byte_en && (cnt_r == 2'(BYTES_PER_WORD - 1))) begin
            word_valid = 1'b1;
        end else begin
            word_valid = 1'b0;
        end
    end

    // Byte counter and accumulator; the 2-bit counter wraps to 0 after byte 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (byte_en) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= next_s;
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/code_loader.sv
// Loads a program frame from the UART byte stream into the code memory.
// Frame: 4-byte word count N, then N 32-bit words written to addresses 0..N-1.
//   clk, rst          : clock and asynchronous active-high reset
//   rx_valid, rx_data : received byte strobe and data
//   restart           : re-arm for a new frame (only acted on when done)
//   we, w_addr, w_data: registered code memory write port
//   loading, done     : frame in progress / frame complete
//   overflow          : sticky, a word addressed above CODE_SIZE was dropped
//   words_loaded      : words accepted in the current frame
module code_loader
    import loader_pkg::*;
#(
    parameter int unsigned CODE_SIZE  = 32'd32767,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        restart,
    output logic        we,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        loading,
    output logic        done,
    output logic        overflow,
    output logic [31:0] words_loaded
);

    loader_state_t state_r;
    logic [31:0]   n_r;
    logic [31:0]   addr_r;
    logic [31:0]   words_r;
    logic          we_r;
    logic [31:0]   w_addr_r;
    logic [31:0]   w_data_r;
    logic          loading_r;
    logic          done_r;
    logic          overflow_r;

    logic          rx_accept_s;
    logic          rearm_s;
    logic          word_valid_s;
    logic [31:0]   word_s;
    logic [31:0]   words_next_s;

    // Bytes arriving after the frame is complete never reach the assembler.
    assign rx_accept_s  = rx_valid && (state_r != S_DONE);
    assign rearm_s      = restart && (state_r == S_DONE);
    assign words_next_s = words_r + 32'd1;

    byte_assembler #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (rearm_s),
        .byte_en    (rx_accept_s),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Frame FSM, counters and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_LEN;
            n_r        <= 32'd0;
            addr_r     <= 32'd0;
            words_r    <= 32'd0;
            we_r       <= 1'b0;
            w_addr_r   <= 32'd0;
            w_data_r   <= 32'd0;
            loading_r  <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (state_r)
                S_LEN: begin
                    if (rx_accept_s) begin
                        loading_r <= 1'b1;
                    end
                    if (word_valid_s) begin
                        n_r <= word_s;
                        if (word_s == 32'd0) begin
                            state_r   <= S_DONE;
                            done_r    <= 1'b1;
                            loading_r <= 1'b0;
                        end else begin
                            state_r <= S_DATA;
                            addr_r  <= 32'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid_s) begin
                        // Words beyond the memory are counted but not written.
                        if (addr_r <= CODE_SIZE) begin
                            we_r     <= 1'b1;
                            w_addr_r <= addr_r;
                            w_data_r <= word_s;
                        end else begin
                            overflow_r <= 1'b1;
                        end
                        addr_r  <= addr_r + 32'd1;
                        words_r <= words_next_s;
                        if (words_next_s == n_r) begin
                            state_r   <= S_DONE;
                            done_r    <= 1'b1;
                            loading_r <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    loading_r <= 1'b0;
                    if (restart) begin
                        state_r    <= S_LEN;
                        done_r     <= 1'b0;
                        words_r    <= 32'd0;
                        addr_r     <= 32'd0;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_LEN;
                    loading_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign we           = we_r;
    assign w_addr       = w_addr_r;
    assign w_data       = w_data_r;
    assign loading      = loading_r;
    assign done         = done_r;
    assign overflow     = overflow_r;
    assign words_loaded = words_r;

endmodule

// File: tb/tb_code_loader.sv
// Scoreboard bench for code_loader: one little-endian and one big-endian
// instance, both with a small code memory so the overflow path is reachable.
module tb_code_loader;

    localparam int CS = 5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid_a, rx_valid_b;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        restart_a, restart_b;
    logic        we_a, we_b;
    logic [31:0] w_addr_a, w_addr_b, w_data_a, w_data_b;
    logic        loading_a, loading_b, done_a, done_b, overflow_a, overflow_b;
    logic [31:0] words_a, words_b;

    wr_t         q_a[$];
    wr_t         q_b[$];
    logic [31:0] frame_words[$];
    bit          in_done[2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    code_loader #(.CODE_SIZE(CS), .BIG_ENDIAN(1'b0)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .restart(restart_a), .we(we_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .loading(loading_a), .done(done_a), .overflow(overflow_a),
        .words_loaded(words_a));

    code_loader #(.CODE_SIZE(CS), .BIG_ENDIAN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .restart(restart_b), .we(we_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .loading(loading_b), .done(done_b), .overflow(overflow_b),
        .words_loaded(words_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_done(input int sel);
        return (sel == 0) ? {31'd0, done_a} : {31'd0, done_b};
    endfunction
    function automatic logic [31:0] get_loading(input int sel);
        return (sel == 0) ? {31'd0, loading_a} : {31'd0, loading_b};
    endfunction
    function automatic logic [31:0] get_ovf(input int sel);
        return (sel == 0) ? {31'd0, overflow_a} : {31'd0, overflow_b};
    endfunction
    function automatic logic [31:0] get_words(input int sel);
        return (sel == 0) ? words_a : words_b;
    endfunction
    function automatic logic [31:0] get_qsize(input int sel);
        return (sel == 0) ? q_a.size() : q_b.size();
    endfunction

    // Write monitors: every write must match the next expected one.
    always @(negedge clk) begin
        wr_t e;
        if (we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_we", w_addr_a, 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                check("a_w_addr", w_addr_a, e.addr);
                check("a_w_data", w_data_a, e.data);
                check("a_done_with_we", {31'd0, done_a}, {31'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_we", w_addr_b, 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                check("b_w_addr", w_addr_b, e.addr);
                check("b_w_data", w_data_b, e.data);
                check("b_done_with_we", {31'd0, done_b}, {31'd0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input int gap_max);
        repeat ($urandom_range(gap_max, 0)) tick();
        if (sel == 0) begin
            rx_valid_a = 1'b1; rx_data_a = b;
        end else begin
            rx_valid_b = 1'b1; rx_data_b = b;
        end
        tick();
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic do_restart(input int sel);
        if (sel == 0) restart_a = 1'b1; else restart_b = 1'b1;
        tick();
        restart_a = 1'b0;
        restart_b = 1'b0;
        in_done[sel] = 1'b0;
        check("restart_done_clr", get_done(sel), 32'd0);
        check("restart_words_clr", get_words(sel), 32'd0);
        check("restart_ovf_clr", get_ovf(sel), 32'd0);
    endtask

    task automatic put_word(input int sel, input logic [31:0] w, inout logic [7:0] bs[$]);
        for (int k = 0; k < 4; k++) begin
            if (sel == 0) bs.push_back(w[8*k +: 8]);
            else          bs.push_back(w[8*(3-k) +: 8]);
        end
    endtask

    // Sends frame_words as one frame to instance sel and checks the outcome.
    task automatic run_frame(input int sel, input int gap_max);
        logic [31:0] n;
        logic [7:0]  bs[$];
        wr_t         e;
        n = frame_words.size();
        if (in_done[sel]) do_restart(sel);
        put_word(sel, n, bs);
        for (int i = 0; i < int'(n); i++) begin
            put_word(sel, frame_words[i], bs);
            if (i <= CS) begin
                e.addr = i;
                e.data = frame_words[i];
                e.last = (i == int'(n) - 1);
                if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
            end
        end
        for (int j = 0; j < bs.size(); j++) begin
            if (j == bs.size() - 1) check("done_early", get_done(sel), 32'd0);
            send_byte(sel, bs[j], gap_max);
            if (j == 0) check("loading_on_first_byte", get_loading(sel), 32'd1);
        end
        check("done_after_last_byte", get_done(sel), 32'd1);
        check("loading_when_done", get_loading(sel), 32'd0);
        check("words_loaded", get_words(sel), n);
        check("overflow", get_ovf(sel), (n > CS + 1) ? 32'd1 : 32'd0);
        tick();
        check("writes_outstanding", get_qsize(sel), 32'd0);
        in_done[sel] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rx_valid_a = 1'b0; rx_valid_b = 1'b0;
        rx_data_a = 8'd0;  rx_data_b = 8'd0;
        restart_a = 1'b0;  restart_b = 1'b0;
        repeat (3) tick();
        check("rst_we", {31'd0, we_a | we_b}, 32'd0);
        check("rst_w_addr", w_addr_a | w_addr_b, 32'd0);
        check("rst_w_data", w_data_a | w_data_b, 32'd0);
        check("rst_flags", {28'd0, loading_a | loading_b, done_a | done_b, overflow_a, overflow_b}, 32'd0);
        check("rst_words", words_a | words_b, 32'd0);
        rst = 1'b0;
        tick();

        // Little-endian two-word frame, bytes back-to-back.
        frame_words = '{32'h0000_0013, 32'hDEAD_BEEF};
        run_frame(0, 0);

        // Big-endian single-word frame with idle gaps.
        frame_words = '{32'h1234_5678};
        run_frame(1, 2);

        // Empty frame, then bytes that must be ignored while done.
        frame_words = {};
        run_frame(0, 0);
        for (int i = 0; i < 8; i++) send_byte(0, 8'($urandom), 0);
        tick();
        check("drop_done", get_done(0), 32'd1);
        check("drop_words", get_words(0), 32'd0);

        // restart coinciding with a byte: the byte must be dropped.
        restart_a = 1'b1; rx_valid_a = 1'b1; rx_data_a = 8'h01;
        tick();
        restart_a = 1'b0; rx_valid_a = 1'b0;
        in_done[0] = 1'b0;
        check("restart_rx_done_clr", get_done(0), 32'd0);
        frame_words = '{32'h0000_0073};
        run_frame(0, 1);

        // Frame exactly filling the memory, then one word too many.
        frame_words = {};
        for (int i = 0; i <= CS; i++) frame_words.push_back($urandom);
        run_frame(0, 0);
        frame_words.push_back($urandom);
        run_frame(0, 1);

        // restart outside done has no effect on a running frame.
        frame_words = '{32'hCAFE_0001, 32'hCAFE_0002};
        do_restart(1);
        restart_b = 1'b1;
        run_frame(1, 0);
        restart_b = 1'b0;

        // Reset in the middle of a data word.
        if (in_done[0]) do_restart(0);
        send_byte(0, 8'h02, 0); send_byte(0, 8'h00, 0);
        send_byte(0, 8'h00, 0); send_byte(0, 8'h00, 0);
        send_byte(0, 8'h11, 0); send_byte(0, 8'h22, 0);
        rst = 1'b1;
        tick();
        check("midrst_loading", get_loading(0), 32'd0);
        check("midrst_words", get_words(0), 32'd0);
        rst = 1'b0;
        in_done[0] = 1'b0;
        in_done[1] = 1'b0;
        tick();
        frame_words = '{32'hAABB_CCDD};
        run_frame(0, 0);

        // Randomised frames on both instances.
        for (int f = 0; f < 12; f++) begin
            int sel;
            int n;
            sel = $urandom_range(1, 0);
            n   = $urandom_range(CS + 3, 0);
            frame_words = {};
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            run_frame(sel, $urandom_range(3, 0));
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
